// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes, ALU ops,
// instruction classes and the decoded-instruction bundle.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    ALU,
    LOAD,
    STORE,
    BR,
    ILL
  } class_e;

  typedef enum logic [1:0] {
    BR_NONE,
    BR_B,
    BR_EQ,
    BR_NE
  } br_kind_e;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  typedef struct packed {
    class_e     cls;
    logic [3:0] alu_func;
    logic       alu_bin_sel;
    logic       byte_op;
    br_kind_e   br_kind;
  } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode/func decode into class, ALU op, operand select,
// byte-width flag and branch kind; zero latency, no flow control.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] func_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o             = '0;
    dec_o.cls         = ILL;
    dec_o.alu_func    = ALU_ADD;
    dec_o.alu_bin_sel = 1'b0;
    dec_o.byte_op     = 1'b0;
    dec_o.br_kind     = BR_NONE;
    unique case (opcode_i)
      OP_RTYPE: begin
        // Only the func[5:4] = 11 slice of the R-type space is implemented.
        if (func_i[5:4] == 2'b11) begin
          dec_o.cls      = ALU;
          dec_o.alu_func = func_i[3:0];
        end
      end
      OP_ADDI, OP_LI: begin
        dec_o.cls         = ALU;
        dec_o.alu_bin_sel = 1'b1;
      end
      OP_ORI: begin
        dec_o.cls         = ALU;
        dec_o.alu_func    = ALU_OR;
        dec_o.alu_bin_sel = 1'b1;
      end
      OP_LW, OP_LB: begin
        dec_o.cls         = LOAD;
        dec_o.alu_bin_sel = 1'b1;
        dec_o.byte_op     = (opcode_i == OP_LB);
      end
      OP_SW, OP_SB: begin
        dec_o.cls         = STORE;
        dec_o.alu_bin_sel = 1'b1;
        dec_o.byte_op     = (opcode_i == OP_SB);
      end
      OP_B: begin
        dec_o.cls     = BR;
        dec_o.br_kind = BR_B;
      end
      OP_BEQ: begin
        dec_o.cls      = BR;
        dec_o.alu_func = ALU_SUB;
        dec_o.br_kind  = BR_EQ;
      end
      OP_BNE: begin
        dec_o.cls      = BR;
        dec_o.alu_func = ALU_SUB;
        dec_o.br_kind  = BR_NE;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle control FSM: latches the instruction in FETCH and sequences it
// through DECODE/EXEC/MEM/WB over 2-5 cycles; Moore outputs, never stalls.
module control_fsm
  import ctrl_pkg::*;
(
  input  logic        Clk,
  input  logic        reset,
  input  logic [31:0] InstrIF,
  output logic [3:0]  ALU_func,
  output logic        ALU_Bin_sel,
  output logic        RF_B_sel,
  output logic        RF_WrData_sel,
  output logic        RF_WrEn,
  output logic        MEM_WrEn,
  output logic        Mem_Out_sel,
  output logic        Mem_DataIn_sel,
  output logic        b,
  output logic        beq,
  output logic        bne,
  output logic        PC_LdEn,
  output logic        illegal,
  output logic [2:0]  state
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  dec_t        dec;

  instr_decoder u_dec (
    .opcode_i (ir_q[31:26]),
    .func_i   (ir_q[5:0]),
    .dec_o    (dec)
  );

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q <= FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  assign ir_d  = (state_q == FETCH) ? InstrIF : ir_q;
  assign state = state_q;

  always_comb begin
    state_d = FETCH;
    unique case (state_q)
      FETCH:   state_d = DECODE;
      DECODE:  state_d = (dec.cls == ILL) ? FETCH : EXEC;
      EXEC: begin
        if (dec.cls == BR)       state_d = FETCH;
        else if (dec.cls == ALU) state_d = WB;
        else                     state_d = MEM;
      end
      MEM:     state_d = (dec.cls == LOAD) ? WB : FETCH;
      WB:      state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Every output is gated by state, so the stale IR seen during FETCH never leaks.
  always_comb begin
    ALU_func       = 4'd0;
    ALU_Bin_sel    = 1'b0;
    RF_B_sel       = 1'b0;
    RF_WrData_sel  = 1'b0;
    RF_WrEn        = 1'b0;
    MEM_WrEn       = 1'b0;
    Mem_Out_sel    = 1'b0;
    Mem_DataIn_sel = 1'b0;
    b              = 1'b0;
    beq            = 1'b0;
    bne            = 1'b0;
    PC_LdEn        = 1'b0;
    illegal        = 1'b0;

    if (state_q != FETCH) begin
      RF_B_sel = (dec.cls == STORE) || (dec.br_kind == BR_EQ) || (dec.br_kind == BR_NE);
    end
    if (state_q == EXEC || state_q == MEM || state_q == WB) begin
      ALU_func    = dec.alu_func;
      ALU_Bin_sel = dec.alu_bin_sel;
    end
    Mem_DataIn_sel = (dec.cls == STORE) && dec.byte_op && (state_q == EXEC || state_q == MEM);
    Mem_Out_sel    = (dec.cls == LOAD)  && dec.byte_op && (state_q == MEM  || state_q == WB);
    MEM_WrEn       = (dec.cls == STORE) && (state_q == MEM);
    RF_WrEn        = (state_q == WB);
    RF_WrData_sel  = (dec.cls == LOAD)  && (state_q == WB);
    b              = (state_q == EXEC) && (dec.br_kind == BR_B);
    beq            = (state_q == EXEC) && (dec.br_kind == BR_EQ);
    bne            = (state_q == EXEC) && (dec.br_kind == BR_NE);
    illegal        = (state_q == DECODE) && (dec.cls == ILL);
    PC_LdEn        = illegal
                   || ((state_q == EXEC) && (dec.cls == BR))
                   || ((state_q == MEM)  && (dec.cls == STORE))
                   || (state_q == WB);
  end

endmodule
